// File: rtl/vdp_defs.sv
// Shared definitions for the VDP CPU bus port: register offsets,
// access FSM states, STATUS bit positions and reset defaults.
package vdp_defs;

  localparam logic [3:0] OFF_CTRL     = 4'h0;
  localparam logic [3:0] OFF_STATUS   = 4'h1;
  localparam logic [3:0] OFF_VADDR_LO = 4'h2;
  localparam logic [3:0] OFF_VADDR_HI = 4'h3;
  localparam logic [3:0] OFF_VDATA    = 4'h4;
  localparam logic [3:0] OFF_VINC     = 4'h5;
  localparam logic [3:0] OFF_SCROLL_X = 4'h6;
  localparam logic [3:0] OFF_SCROLL_Y = 4'h7;
  localparam logic [3:0] OFF_BORDER   = 4'h8;

  localparam int ST_VBLANK_BIT = 7;
  localparam int ST_BUSY_BIT   = 6;

  localparam logic [7:0] VINC_DEFAULT = 8'h01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_PEND = 2'd1,
    RD_PEND = 2'd2
  } vdp_state_e;

endpackage

// File: rtl/vdp_edge_detect.sv
// vblank synchroniser with a registered rising-edge pulse.
module vdp_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sh <= 3'b000;
    else        sh <= {sh[1:0], din};
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/vdp_bus_port.sv
// CPU register window for the VDP with a buffered VRAM port.
// Optional: define VDP_IRQ_EN to gate irq with CTRL bit0.
module vdp_bus_port #(
  parameter logic [15:0] BASE_ADDR = 16'hFFF0,
  parameter int          VRAM_AW   = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        address,
  input  logic [7:0]         data_in,
  output logic [7:0]         data_out,
  input  logic               wr,
  input  logic               rd,
  output logic               sel,
  input  logic               vblank,
  output logic               irq,
  output logic [7:0]         ctrl,
  output logic [7:0]         scroll_x,
  output logic [7:0]         scroll_y,
  output logic [3:0]         border,
  output logic               vram_req,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  input  logic               vram_ack,
  input  logic [7:0]         vram_rdata
);
  import vdp_defs::*;

  vdp_state_e state, state_nx;

  logic [3:0]         off;
  logic               wr_hit, rd_hit;
  logic               busy, vport;
  logic               start_wr, start_rd, done;
  logic               rise, flag;
  logic [7:0]         vinc, rbuf, rmux;
  logic [15:0]        va16;
  logic [VRAM_AW-1:0] vaddr, va_lo, va_hi;
  logic [VRAM_AW-1:0] fetch_addr;

  assign sel    = address[15:4] == BASE_ADDR[15:4];
  assign off    = address[3:0];
  assign wr_hit = wr & sel;
  assign rd_hit = rd & sel;
  assign busy   = state != IDLE;

  assign vport = (off == OFF_VADDR_LO) |
                 (off == OFF_VADDR_HI) |
                 (off == OFF_VDATA);

  assign start_wr = wr_hit & ~busy &
                    (off == OFF_VDATA);
  assign start_rd = ~busy & (
    (wr_hit & ((off == OFF_VADDR_LO) |
               (off == OFF_VADDR_HI))) |
    (rd_hit & (off == OFF_VDATA)));
  assign done = busy & vram_ack;

  assign va16  = 16'(vaddr);
  assign va_lo = VRAM_AW'({va16[15:8], data_in});
  assign va_hi = VRAM_AW'({data_in, va16[7:0]});

  // A VADDR write fetches from the address being written
  always_comb begin
    fetch_addr = vaddr;
    if (off == OFF_VADDR_LO)
      fetch_addr = va_lo;
    else if (off == OFF_VADDR_HI)
      fetch_addr = va_hi;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      start_wr: state_nx = WR_PEND;
      start_rd: state_nx = RD_PEND;
      done:     state_nx = IDLE;
      default:  state_nx = state;
    endcase
  end

  assign vram_req = busy;
  assign vram_we  = state == WR_PEND;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= 8'h00;
      scroll_x <= 8'h00;
      scroll_y <= 8'h00;
      border   <= 4'h0;
      vinc     <= VINC_DEFAULT;
    end else if (wr_hit) begin
      case (off)
        OFF_CTRL:     ctrl     <= data_in;
        OFF_VINC:     vinc     <= data_in;
        OFF_SCROLL_X: scroll_x <= data_in;
        OFF_SCROLL_Y: scroll_y <= data_in;
        OFF_BORDER:   border   <= data_in[3:0];
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vaddr      <= '0;
      vram_addr  <= '0;
      vram_wdata <= 8'h00;
      rbuf       <= 8'h00;
    end else begin
      if (start_wr) begin
        vram_wdata <= data_in;
        vram_addr  <= vaddr;
      end else if (start_rd) begin
        vram_addr  <= fetch_addr;
      end
      if (done)
        vaddr <= vaddr + VRAM_AW'(vinc);
      else if (start_rd & wr_hit)
        vaddr <= fetch_addr;
      if (done & (state == RD_PEND))
        rbuf <= vram_rdata;
    end
  end

  always_comb begin
    rmux = 8'h00;
    unique case (1'b1)
      off == OFF_CTRL:     rmux = ctrl;
      off == OFF_STATUS: begin
        rmux[ST_VBLANK_BIT] = flag;
        rmux[ST_BUSY_BIT]   = busy;
      end
      off == OFF_VADDR_LO: rmux = va16[7:0];
      off == OFF_VADDR_HI: rmux = va16[15:8];
      off == OFF_VDATA:    rmux = rbuf;
      off == OFF_VINC:     rmux = vinc;
      off == OFF_SCROLL_X: rmux = scroll_x;
      off == OFF_SCROLL_Y: rmux = scroll_y;
      off == OFF_BORDER:   rmux = {4'h0, border};
      default:             rmux = 8'h00;
    endcase
  end

  // Port reads while busy are dropped and leave data_out alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      data_out <= 8'h00;
    else if (rd_hit & ~(busy & vport))
      data_out <= rmux;
  end

  vdp_edge_detect u_vbl (
    .clk   (clk),
    .reset (reset),
    .din   (vblank),
    .rise  (rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      flag <= 1'b0;
    else if (rise)
      flag <= 1'b1;
    else if (rd_hit & (off == OFF_STATUS))
      flag <= 1'b0;
  end

`ifdef VDP_IRQ_EN
  assign irq = flag & ctrl[0];
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_vdp_bus_port.sv
// Self-checking bench for vdp_bus_port: vector table, directed
// handshake/vblank/reset sequences and a random model-checked run.
module tb_vdp_bus_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        wr, rd, sel, vblank, irq;
  logic [7:0]  ctrl, scroll_x, scroll_y;
  logic [3:0]  border;
  logic        vram_req, vram_we, vram_ack;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata, vram_rdata;

  vdp_bus_port dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .data_in    (data_in),
    .data_out   (data_out),
    .wr         (wr),
    .rd         (rd),
    .sel        (sel),
    .vblank     (vblank),
    .irq        (irq),
    .ctrl       (ctrl),
    .scroll_x   (scroll_x),
    .scroll_y   (scroll_y),
    .border     (border),
    .vram_req   (vram_req),
    .vram_we    (vram_we),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_ack   (vram_ack),
    .vram_rdata (vram_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] vram [16384];
  logic [7:0] mref [16384];
  bit         hold = 1'b0;
  int         nwrites = 0;

  // VRAM responder: random grant latency unless held off
  initial begin
    int dly;
    dly = 0;
    for (int i = 0; i < 16384; i++)
      vram[i] = 8'($urandom);
    vram_ack   = 1'b0;
    vram_rdata = 8'h00;
    forever begin
      @(negedge clk);
      vram_ack = 1'b0;
      if (vram_req && !hold && reset) begin
        if (dly == 0) begin
          vram_ack = 1'b1;
          if (vram_we) begin
            vram[vram_addr] = vram_wdata;
            nwrites++;
          end else begin
            vram_rdata = vram[vram_addr];
          end
          dly = $urandom_range(0, 3);
        end else begin
          dly--;
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a,
                        input logic [7:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    wr      = 1'b1;
    @(negedge clk);
    wr      = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a,
                        output logic [7:0] d);
    @(negedge clk);
    address = a;
    rd      = 1'b1;
    @(negedge clk);
    rd      = 1'b0;
    d       = data_out;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 60; i++) begin
      if (!vram_req) break;
      @(negedge clk);
    end
    chk({nm, "_idle"}, 32'(vram_req), 32'd0);
  endtask

  // Behavioural model of the register window
  int         mva, mvinc;
  logic [7:0] mctrl, msx, msy, mbuf;
  logic [3:0] mbord;

  task automatic madv();
    mva = (mva + mvinc) % 16384;
  endtask

  task automatic mfetch();
    mbuf = mref[mva];
    madv();
  endtask

  task automatic op(input bit w,
                    input logic [3:0] o,
                    input logic [7:0] d);
    logic [7:0] got, exp;
    if (w) begin
      bus_wr({12'hFFF, o}, d);
      case (o)
        4'h0: mctrl = d;
        4'h2: begin
          mva = (mva & 'h3F00) | int'(d);
          mfetch();
        end
        4'h3: begin
          mva = ((int'(d) << 8) | (mva & 'hFF))
                & 'h3FFF;
          mfetch();
        end
        4'h4: begin
          mref[mva] = d;
          madv();
        end
        4'h5: mvinc = int'(d);
        4'h6: msx = d;
        4'h7: msy = d;
        4'h8: mbord = d[3:0];
        default: ;
      endcase
      if (o inside {4'h2, 4'h3, 4'h4})
        wait_idle("op_wr");
    end else begin
      case (o)
        4'h0: exp = mctrl;
        4'h2: exp = 8'(mva);
        4'h3: exp = 8'(mva >> 8);
        4'h4: exp = mbuf;
        4'h5: exp = 8'(mvinc);
        4'h6: exp = msx;
        4'h7: exp = msy;
        4'h8: exp = {4'h0, mbord};
        default: exp = 8'h00;
      endcase
      bus_rd({12'hFFF, o}, got);
      chk($sformatf("rand_rd_%0h", o),
          32'(got), 32'(exp));
      if (o == 4'h4) begin
        mfetch();
        wait_idle("op_rd");
      end
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    bit          w;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [7:0] got, exp8;
    logic       exp_irq;
    int         nw0, n80;

`ifdef VDP_IRQ_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif

    tbl[0]  = '{16'hFFF5, 8'h00, 1'b0, 8'h01};
    tbl[1]  = '{16'hFFF0, 8'h00, 1'b0, 8'h00};
    tbl[2]  = '{16'hFFF1, 8'h00, 1'b0, 8'h00};
    tbl[3]  = '{16'hFFF2, 8'h00, 1'b0, 8'h00};
    tbl[4]  = '{16'hFFF6, 8'hA5, 1'b1, 8'h00};
    tbl[5]  = '{16'hFFF6, 8'h00, 1'b0, 8'hA5};
    tbl[6]  = '{16'hFFF7, 8'h3C, 1'b1, 8'h00};
    tbl[7]  = '{16'hFFF7, 8'h00, 1'b0, 8'h3C};
    tbl[8]  = '{16'hFFF8, 8'hFF, 1'b1, 8'h00};
    tbl[9]  = '{16'hFFF8, 8'h00, 1'b0, 8'h0F};
    tbl[10] = '{16'hFFF9, 8'h77, 1'b1, 8'h00};
    tbl[11] = '{16'hFFF9, 8'h00, 1'b0, 8'h00};
    tbl[12] = '{16'hFF06, 8'h99, 1'b1, 8'h00};
    tbl[13] = '{16'hFFF6, 8'h00, 1'b0, 8'hA5};
    tbl[14] = '{16'hFFE6, 8'h00, 1'b0, 8'hA5};
    tbl[15] = '{16'hFFFF, 8'h00, 1'b0, 8'h00};
    tbl[16] = '{16'hFFF0, 8'h01, 1'b1, 8'h00};
    tbl[17] = '{16'hFFF0, 8'h00, 1'b0, 8'h01};

    reset   = 1'b0;
    address = 16'h0000;
    data_in = 8'h00;
    wr      = 1'b0;
    rd      = 1'b0;
    vblank  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(vram_req), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].w) begin
        bus_wr(tbl[i].a, tbl[i].d);
      end else begin
        bus_rd(tbl[i].a, got);
        chk($sformatf("tbl_%0d", i),
            32'(got), 32'(tbl[i].exp));
      end
    end
    chk("scroll_x", 32'(scroll_x), 32'hA5);
    chk("scroll_y", 32'(scroll_y), 32'h3C);
    chk("border", 32'(border), 32'hF);
    chk("tbl_irq", 32'(irq), 32'd0);
    chk("tbl_req", 32'(vram_req), 32'd0);

    // VADDR load with read-ahead, then VDATA read
    bus_wr(16'hFFF3, 8'h12);
    wait_idle("a_hi");
    hold = 1'b1;
    bus_wr(16'hFFF2, 8'h34);
    chk("a_req", 32'(vram_req), 32'd1);
    chk("a_we", 32'(vram_we), 32'd0);
    chk("a_addr", 32'(vram_addr), 32'h1234);
    exp8 = vram[14'h1234];
    hold = 1'b0;
    wait_idle("a_fetch");
    hold = 1'b1;
    bus_rd(16'hFFF4, got);
    chk("a_vdata", 32'(got), 32'(exp8));
    chk("a_req2", 32'(vram_req), 32'd1);
    chk("a_addr2", 32'(vram_addr), 32'h1235);
    hold = 1'b0;
    wait_idle("a_ra");

    // Write at top of VRAM, address wraps
    bus_wr(16'hFFF5, 8'h10);
    bus_wr(16'hFFF3, 8'h3F);
    wait_idle("b_hi");
    bus_wr(16'hFFF2, 8'hE8);
    wait_idle("b_lo");
    hold = 1'b1;
    bus_wr(16'hFFF4, 8'h55);
    chk("b_we", 32'(vram_we), 32'd1);
    chk("b_addr", 32'(vram_addr), 32'h3FF8);
    chk("b_wdata", 32'(vram_wdata), 32'h55);
    hold = 1'b0;
    wait_idle("b_wr");
    bus_rd(16'hFFF2, got);
    chk("b_va_lo", 32'(got), 32'h08);
    bus_rd(16'hFFF3, got);
    chk("b_va_hi", 32'(got), 32'h00);
    chk("b_mem", 32'(vram[14'h3FF8]), 32'h55);

    // Write with grant withheld: busy, second write dropped
    nw0  = nwrites;
    hold = 1'b1;
    bus_wr(16'hFFF4, 8'hAA);
    repeat (5) @(negedge clk);
    bus_rd(16'hFFF1, got);
    chk("c_busy", 32'(got), 32'h40);
    bus_wr(16'hFFF4, 8'hBB);
    hold = 1'b0;
    wait_idle("c_wr");
    repeat (3) @(negedge clk);
    chk("c_nwr", 32'(nwrites - nw0), 32'd1);
    chk("c_mem", 32'(vram[14'h0008]), 32'hAA);

    // vblank flag and irq
    bus_wr(16'hFFF0, 8'h01);
    vblank = 1'b1;
    repeat (6) @(negedge clk);
    chk("d_irq", 32'(irq), 32'(exp_irq));
    bus_rd(16'hFFF1, got);
    chk("d_stat", 32'(got), 32'h80);
    chk("d_irq_clr", 32'(irq), 32'd0);
    bus_rd(16'hFFF1, got);
    chk("d_stat2", 32'(got), 32'h00);
    vblank = 1'b0;
    repeat (6) @(negedge clk);
    // Continuous STATUS reads across a rise: one must see it
    address = 16'hFFF1;
    rd      = 1'b1;
    vblank  = 1'b1;
    n80     = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (data_out == 8'h80) n80++;
    end
    rd = 1'b0;
    chk("d_coinc", 32'(n80), 32'd1);
    chk("d_irq_end", 32'(irq), 32'd0);
    vblank = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of a handshake
    hold = 1'b1;
    bus_wr(16'hFFF4, 8'h11);
    chk("e_req", 32'(vram_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("e_req_rst", 32'(vram_req), 32'd0);
    chk("e_we", 32'(vram_we), 32'd0);
    chk("e_addr", 32'(vram_addr), 32'd0);
    chk("e_wdata", 32'(vram_wdata), 32'd0);
    chk("e_ctrl", 32'(ctrl), 32'd0);
    chk("e_sx", 32'(scroll_x), 32'd0);
    chk("e_sy", 32'(scroll_y), 32'd0);
    chk("e_bord", 32'(border), 32'd0);
    chk("e_dout", 32'(data_out), 32'd0);
    chk("e_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    hold  = 1'b0;

    for (int i = 0; i < 16384; i++)
      mref[i] = vram[i];
    mva   = 0;
    mvinc = 1;
    mbuf  = 8'h00;
    mctrl = 8'h00;
    msx   = 8'h00;
    msy   = 8'h00;
    mbord = 4'h0;

    op(1'b0, 4'h5, 8'h00);
    op(1'b0, 4'h4, 8'h00);

    for (int i = 0; i < 250; i++)
      op(1'($urandom), 4'($urandom),
         8'($urandom));

    chk("f_ctrl", 32'(ctrl), 32'(mctrl));
    chk("f_sx", 32'(scroll_x), 32'(msx));
    chk("f_sy", 32'(scroll_y), 32'(msy));
    chk("f_bord", 32'(border), 32'(mbord));

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
